// File: rtl/divider.sv
// rtl/divider.sv - 8-bit unsigned restoring divider, one quotient bit per clock
// Remainder output port R is present only when DIV_REMAINDER_EN is defined.
module divider (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] dA,
  input  logic [7:0] dB,
  input  logic       div_start,
  output logic [7:0] Q,
`ifdef DIV_REMAINDER_EN
  output logic [7:0] R,
`endif
  output logic       div_complete,
  output logic       div_busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] dvd_q, dvd_d;
  logic [7:0] dvs_q, dvs_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] q_d;
  logic       complete_d;
  logic       busy_d;

  logic [8:0] shifted;
  logic       ge;
  logic [7:0] step_rem;
  logic [7:0] step_dvd;

  // The stored partial remainder is always below the divisor, so only the
  // shifted value needs the ninth bit; an 8-bit subtract is exact when ge.
  always_comb begin
    shifted  = {rem_q, dvd_q[7]};
    ge       = shifted >= {1'b0, dvs_q};
    step_rem = ge ? (shifted[7:0] - dvs_q) : shifted[7:0];
    step_dvd = {dvd_q[6:0], ge};
  end

`ifdef DIV_REMAINDER_EN
  logic [7:0] r_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    q_d        = Q;
    complete_d = 1'b0;
`ifdef DIV_REMAINDER_EN
    r_d        = R;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (div_start) begin
          dvd_d   = dA;
          dvs_d   = dB;
          rem_d   = 8'd0;
          cnt_d   = 3'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        dvd_d = step_dvd;
        rem_d = step_rem;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          q_d        = step_dvd;
          complete_d = 1'b1;
          state_d    = DONE;
`ifdef DIV_REMAINDER_EN
          r_d        = step_rem;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      dvd_q        <= 8'd0;
      dvs_q        <= 8'd0;
      rem_q        <= 8'd0;
      Q            <= 8'd0;
      div_complete <= 1'b0;
      div_busy     <= 1'b0;
`ifdef DIV_REMAINDER_EN
      R            <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      rem_q        <= rem_d;
      Q            <= q_d;
      div_complete <= complete_d;
      div_busy     <= busy_d;
`ifdef DIV_REMAINDER_EN
      R            <= r_d;
`endif
    end
  end

endmodule

// File: doc/divider.md
# divider

Multi-cycle unsigned 8-bit restoring divider: the responder on the divider handshake driven by the CPU controller (`dA`, `dB`, `div_start` in; `Q`, `div_complete` out). Accepts a dividend/divisor pair on a start request, produces one quotient bit per cycle over eight cycles, then pulses completion with the quotient held stable. Sits beside the general ALU and multiplier and serves the DIV instruction, which stalls the program counter until `div_complete`.

## Interface
- No parameters; width fixed at 8 bits.
- `clock`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clock`
- `dA`  in  8  dividend (unsigned), sampled only on the accepting edge
- `dB`  in  8  divisor (unsigned), sampled only on the accepting edge
- `div_start`  in  1  start request, level-sampled on rising edge
- `Q`  out  8  quotient, registered; holds last result until next completion
- `div_complete`  out  1  one-cycle completion pulse, registered
- `div_busy`  out  1  high while in RUN or DONE, registered
- `R`  out  8  remainder, registered; present only with `DIV_REMAINDER_EN`

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- Reset values: `Q`=0, `R`=0, `div_complete`=0, `div_busy`=0, step counter=0, working registers=0.
- IDLE: `div_start`=1 at an edge -> latch `dA` into working dividend/quotient shift register, `dB` into divisor register, clear 9-bit partial remainder, counter=0, go RUN. Otherwise stay.
- RUN, one step per edge: partial = {partial[7:0], dividend MSB}; shift dividend left; if partial >= {1'b0, divisor} then partial -= divisor and shift in quotient bit 1, else 0. Counter increments; after step 8 (counter wraps 7->0) load `Q` (and `R`) from working registers, go DONE.
- Comparison and subtraction 9 bits wide; no overflow possible; partial[8] never set after a step.
- DONE (exactly one cycle): `div_complete`=1. Next edge: `div_start`=1 -> accept new operands as in IDLE, go RUN (back-to-back); else go IDLE.
- `div_start` in RUN is ignored; operands are not re-sampled; in-flight division unaffected.
- Divide by zero: no special case; the algorithm yields `Q`=8'hFF, remainder=`dA`, same latency.
- Reset asserted in any state, including mid-RUN: next edge forces all reset values; partial result discarded; `Q` cleared. Reset wins over simultaneous `div_start`.

## Timing
- Edge 0: `div_start` sampled high in IDLE/DONE; `div_busy` rises after edge 0.
- Edges 1-8: eight iteration steps.
- After edge 8: `Q` (and `R`) valid, `div_complete`=1, `div_busy`=1.
- After edge 9: `div_complete`=0; `div_busy`=0 unless a new start was accepted at edge 9.
- Latency start-edge to completion: 8 cycles; throughput one division per 9 cycles, back-to-back.
- `Q`/`R` change only on the edge entering DONE (or reset); stable otherwise, including through RUN of the next division.
- No combinational path from inputs to outputs.

## Configuration
- `DIV_REMAINDER_EN` defined: port `R` exists and is loaded with the final partial remainder (low 8 bits) on the edge entering DONE; reset value 0.
- Not defined: port `R` and its output register are absent; remainder stays internal; quotient behaviour and timing identical.

## Test plan
- Reset, then `dA`=200, `dB`=7, `div_start` for one cycle -> `div_complete` pulses exactly one cycle, 8 cycles after start edge, `Q`=28 (`R`=4); `Q` held 28 afterward.
- `dA`=5, `dB`=0 -> `Q`=8'hFF (`R`=5), normal 8-cycle latency.
- `dA`=255,`dB`=1 then held `div_start`=1 through DONE with `dA`=13,`dB`=13 -> first `Q`=255, second accepted at edge 9, `Q`=1 (`R`=0) after edge 17; `div_busy` never drops.
- Start 100/9, then pulse `div_start` with `dA`=50,`dB`=5 at edge 4 (RUN) -> ignored; `Q`=11 (`R`=1), single `div_complete`.
- Start 200/7, assert `reset` at edge 5 -> after edge 5 all outputs 0, state IDLE; no `div_complete` appears; following 9/3 -> `Q`=3.
